// File: rtl/draw_sequencer.sv
// draw_sequencer: runs drawing engines in order and muxes the active one onto the VGA plot port
module draw_sequencer #(
  parameter int N_ENG      = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic [N_ENG-1:0]   eng_done,
  input  logic [8*N_ENG-1:0] eng_x,
  input  logic [7*N_ENG-1:0] eng_y,
  input  logic [3*N_ENG-1:0] eng_colour,
  input  logic [N_ENG-1:0]   eng_plot,
  output logic [N_ENG-1:0]   eng_start,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot,
  output logic               busy,
  output logic               all_done,
  output logic [CNT_W-1:0]   plot_count
);
  localparam int IW = N_ENG > 1 ? $clog2(N_ENG) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] x_q;
  logic [6:0] y_q;
  logic [2:0] col_q;
  logic run;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_col;
  assign run        = !rst && state_q == RUN;
  assign sel_x      = eng_x[8*idx_q +: 8];
  assign sel_y      = eng_y[7*idx_q +: 7];
  assign sel_col    = eng_colour[3*idx_q +: 3];
  assign vga_x      = rst ? '0 : run ? sel_x : x_q;
  assign vga_y      = rst ? '0 : run ? sel_y : y_q;
  assign vga_colour = rst ? '0 : run ? sel_col : col_q;
  assign vga_plot   = run && eng_plot[idx_q];
  assign eng_start  = run ? N_ENG'(1) << idx_q : '0;
  assign busy       = !rst && (state_q == RUN || state_q == GAP);
  assign all_done   = !rst && state_q == DONE;
  assign plot_count = cnt_q;
  // Sequencing: walk engines in order with a fixed idle gap, then wait for go to drop
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    cnt_d   = (vga_plot && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
    case (state_q)
      IDLE: if (go) begin
        state_d = RUN;
        idx_d   = '0;
        cnt_d   = '0;
      end
      RUN: if (eng_done[idx_q]) begin
        state_d = idx_q == IW'(N_ENG - 1) ? DONE : GAP;
        gap_d   = GW'(GAP_CYCLES - 1);
      end
      GAP: begin
        state_d = gap_q == '0 ? RUN : GAP;
        idx_d   = gap_q == '0 ? idx_q + 1'b1 : idx_q;
        gap_d   = gap_q == '0 ? gap_q : gap_q - 1'b1;
      end
      default: if (!go) state_d = IDLE;
    endcase
  end
  // State and counters; pixel registers remember the last active pixel so the bus never glitches to 0
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      if (run) begin
        x_q   <= sel_x;
        y_q   <= sel_y;
        col_q <= sel_col;
      end
    end
  end
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: directed checks of engine sequencing, pixel muxing, reset and plot counting
module tb_draw_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int tests = 0;
  int fails = 0;
  logic rst, go, mode;
  logic [1:0] m_done, m_plot;
  logic [15:0] m_x;
  logic [13:0] m_y;
  logic [5:0] m_col;
  logic [1:0] e_done, e_plot;
  logic [15:0] e_x;
  logic [13:0] e_y;
  logic [5:0] e_col;
  logic [1:0] start;
  logic [7:0] vx;
  logic [6:0] vy;
  logic [2:0] vc;
  logic vp, busy, adone;
  logic [14:0] pc;
  logic go3;
  logic [1:0] b_done, b_plot, start3;
  logic [7:0] vx3;
  logic [6:0] vy3;
  logic [2:0] vc3;
  logic vp3, busy3, adone3;
  logic [3:0] pc3;
  draw_sequencer #(.N_ENG(2), .GAP_CYCLES(1), .CNT_W(15)) dut (
    .clk(clk), .rst(rst), .go(go), .eng_done(e_done), .eng_x(e_x), .eng_y(e_y),
    .eng_colour(e_col), .eng_plot(e_plot), .eng_start(start), .vga_x(vx), .vga_y(vy),
    .vga_colour(vc), .vga_plot(vp), .busy(busy), .all_done(adone), .plot_count(pc)
  );
  draw_sequencer #(.N_ENG(2), .GAP_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .go(go3), .eng_done(b_done), .eng_x(16'h0102), .eng_y(14'h0000),
    .eng_colour(6'o00), .eng_plot(b_plot), .eng_start(start3), .vga_x(vx3), .vga_y(vy3),
    .vga_colour(vc3), .vga_plot(vp3), .busy(busy3), .all_done(adone3), .plot_count(pc3)
  );
  int fcnt;
  logic fdone, f_plot;
  logic [7:0] f_x;
  logic [6:0] f_y;
  always @(posedge clk)
    if (rst || !start[0]) begin
      fcnt  <= 0;
      fdone <= 1'b0;
    end else if (!fdone) begin
      fdone <= fcnt == 19199;
      fcnt  <= fcnt + 1;
    end
  assign f_plot = start[0] && !fdone;
  assign f_x = 8'(fcnt % 160);
  assign f_y = 7'(fcnt / 160);
  int cx, cy, cd, px, py, c_n;
  logic [2:0] oct;
  logic c_plot, c_done;
  logic [7:0] c_x;
  logic [6:0] c_y;
  assign c_plot = start[1] && cy <= cx;
  assign c_done = start[1] && cy > cx;
  always @(posedge clk)
    if (rst || !start[1]) begin
      cx  <= 40;
      cy  <= 0;
      cd  <= -39;
      oct <= 3'd0;
    end else if (c_plot) begin
      oct <= oct + 3'd1;
      if (oct == 3'd7) begin
        cy <= cy + 1;
        if (cd < 0) cd <= cd + 2 * cy + 3;
        else begin
          cd <= cd + 2 * (cy - cx) + 5;
          cx <= cx - 1;
        end
      end
    end
  always @(posedge clk)
    if (rst) c_n <= 0;
    else if (mode && c_plot) c_n <= c_n + 1;
  always_comb begin
    px = 80;
    py = 60;
    case (oct)
      3'd0: begin px = 80 + cx; py = 60 + cy; end
      3'd1: begin px = 80 + cy; py = 60 + cx; end
      3'd2: begin px = 80 - cy; py = 60 + cx; end
      3'd3: begin px = 80 - cx; py = 60 + cy; end
      3'd4: begin px = 80 - cx; py = 60 - cy; end
      3'd5: begin px = 80 - cy; py = 60 - cx; end
      3'd6: begin px = 80 + cy; py = 60 - cx; end
      default: begin px = 80 + cx; py = 60 - cy; end
    endcase
  end
  assign c_x   = 8'(px);
  assign c_y   = 7'(py);
  assign e_done = mode ? {c_done, fdone} : m_done;
  assign e_plot = mode ? {c_plot, f_plot} : m_plot;
  assign e_x    = mode ? {c_x, f_x} : m_x;
  assign e_y    = mode ? {c_y, f_y} : m_y;
  assign e_col  = mode ? 6'b010_000 : m_col;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask
  initial begin
    int bad, guard;
    logic ep;
    rst = 1'b1; go = 1'b0; mode = 1'b0; m_done = '0; m_plot = '0; m_x = '0; m_y = '0; m_col = '0;
    go3 = 1'b0; b_done = '0; b_plot = '0;
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_all_done", 32'(adone), 32'd0);
    chk("rst_vga", 32'({vx, vy, vc, vp}), 32'd0);
    chk("rst_count", 32'(pc), 32'd0);
    go = 1'b1;
    @(negedge clk);
    chk("rst_blocks_go", 32'(start), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      m_x = {8'($urandom), 8'(10 + k)};
      m_y = {7'($urandom), 7'(k)};
      m_col = {3'($urandom), 3'(k)};
      m_plot = {1'($urandom), 1'b1};
      m_done = {1'($urandom), 1'(k == 4)};
      if (k == 2) go = 1'b0;
      #1;
      chk("run0_start", 32'(start), 32'd1);
      chk("run0_x", 32'(vx), 32'(10 + k));
      chk("run0_y_col", 32'({vy, vc}), 32'({7'(k), 3'(k)}));
      chk("run0_plot_busy", 32'({vp, busy}), 32'd3);
      @(negedge clk);
    end
    m_x = 16'hffff; m_y = '1; m_col = '1; m_plot = 2'b11; m_done = 2'b00;
    #1;
    chk("gap_start", 32'(start), 32'd0);
    chk("gap_plot_busy", 32'({vp, busy, adone}), 32'b010);
    chk("gap_hold_xyc", 32'({vx, vy, vc}), 32'({8'd14, 7'd4, 3'd4}));
    chk("gap_count", 32'(pc), 32'd4);
    @(negedge clk);
    m_x = 16'h3300; m_y = {7'd20, 7'd0}; m_col = {3'd5, 3'd0}; m_plot = 2'b10;
    #1;
    chk("run1_start", 32'(start), 32'd2);
    chk("run1_xyc", 32'({vx, vy, vc, vp}), 32'({8'h33, 7'd20, 3'd5, 1'b1}));
    chk("run1_count", 32'(pc), 32'd4);
    rst = 1'b1;
    #1;
    chk("rst_held_start", 32'({start, vp, busy}), 32'd0);
    @(negedge clk);
    chk("rst_mid_start", 32'(start), 32'd0);
    chk("rst_mid_busy_count", 32'({busy, pc}), 32'd0);
    rst = 1'b0; m_plot = '0; m_done = '0;
    @(negedge clk);
    chk("idle_after_rst", 32'({start, busy, adone}), 32'd0);
    go = 1'b1;
    @(negedge clk);
    chk("restart_run0", 32'(start), 32'd1);
    chk("restart_count", 32'(pc), 32'd0);
    m_done = 2'b01;
    @(negedge clk);
    chk("restart_gap", 32'({start, busy}), 32'b001);
    m_done = 2'b10;
    @(negedge clk);
    chk("restart_run1", 32'(start), 32'd2);
    @(negedge clk);
    chk("done_state", 32'({start, busy, adone}), 32'b0001);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("done_go_held", 32'({start, busy, adone}), 32'b0001);
    end
    go = 1'b0; m_done = '0;
    @(negedge clk);
    chk("done_to_idle", 32'({start, busy, adone}), 32'd0);
    go = 1'b1;
    @(negedge clk);
    chk("idle_to_run0", 32'(start), 32'd1);
    rst = 1'b1; go = 1'b0;
    @(negedge clk);
    rst = 1'b0; mode = 1'b1; go = 1'b1;
    @(negedge clk);
    chk("stub_run0", 32'(start), 32'd1);
    bad = 0;
    for (guard = 0; guard < 30000 && !adone; guard++) begin
      ep = (start[0] && f_plot) || (start[1] && c_plot);
      if (vp !== ep) bad++;
      else if (vp && start[0] && {vx, vy, vc} !== {f_x, f_y, 3'b000}) bad++;
      else if (vp && start[1] && {vx, vy, vc} !== {c_x, c_y, 3'b010}) bad++;
      @(negedge clk);
    end
    chk("stub_finished", 32'(adone), 32'd1);
    chk("stub_pixel_bad", 32'(bad), 32'd0);
    chk("stub_circle_nonzero", 32'(c_n != 0), 32'd1);
    chk("stub_count", 32'(pc), 32'(19200 + c_n));
    go = 1'b0;
    @(negedge clk);
    chk("stub_count_hold", 32'(pc), 32'(19200 + c_n));
    mode = 1'b0;
    go3 = 1'b1; b_done = 2'b11;
    @(negedge clk);
    chk("g3_run0", 32'(start3), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("g3_gap", 32'({start3, busy3}), 32'b001);
    end
    @(negedge clk);
    chk("g3_run1", 32'(start3), 32'd2);
    @(negedge clk);
    chk("g3_done", 32'({start3, adone3}), 32'b001);
    go3 = 1'b0;
    @(negedge clk);
    chk("g3_idle", 32'({start3, adone3}), 32'd0);
    b_done = 2'b00; b_plot = 2'b01; go3 = 1'b1;
    @(negedge clk);
    chk("sat_start", 32'({start3, pc3}), 32'({2'b01, 4'd0}));
    repeat (20) @(negedge clk);
    chk("sat_count", 32'(pc3), 32'd15);
    chk("sat_still_plot", 32'({vp3, vx3}), 32'({1'b1, 8'h02}));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
